// File: rtl/add_seq_pkg.sv
// Shared types, default sizes and the word-index helper for the sequential wide adder.
package add_seq_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned CW_DEF = 4;

    // IDLE expects the first word of a packet, BUSY is mid-packet.
    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    // Index of the word following `idx`; restarts at 0 after the last word, wraps modulo 2^cw.
    function automatic int unsigned next_idx(input int unsigned idx, input logic last,
                                             input int unsigned cw);
        int unsigned mask;
        mask = (32'd1 << cw) - 32'd1;
        if (last) begin
            return 0;
        end
        return (idx + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Combinational N-bit adder with carry in and carry out.
module fulladder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Plain (N+1)-bit unsigned sum; the top bit is the carry out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Streams two long operands word by word (LSW first) through one N-bit adder,
// chaining the carry between words and registering each sum word.
module multiword_add_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_last,
    input  logic          cin_init,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_last,
    output logic          out_cout,
    output logic [CW-1:0] out_idx
);

    state_e        state_q;
    logic          carry_q;
    logic [CW-1:0] idx_q;

    logic          accept;
    logic          cin_sel;
    logic [CW-1:0] idx_sel;
    logic [N-1:0]  fa_sum;
    logic          fa_cout;

    // Single-entry output register: free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A first word ignores any carry left over from the previous packet.
    assign cin_sel = (state_q == StIdle) ? cin_init : carry_q;
    assign idx_sel = (state_q == StIdle) ? '0 : idx_q;

    fulladder #(
        .N (N)
    ) u_fulladder (
        .a    (in_a),
        .b    (in_b),
        .cin  (cin_sel),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Packet FSM plus carry/index state and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_idx   <= '0;
        end else if (accept) begin
            state_q   <= in_last ? StIdle : StBusy;
            carry_q   <= fa_cout;
            idx_q     <= CW'(next_idx(32'(idx_sel), in_last, CW));
            out_valid <= 1'b1;
            out_sum   <= fa_sum;
            out_last  <= in_last;
            out_cout  <= in_last ? fa_cout : 1'b0;
            out_idx   <= idx_sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
